upsample_nearest_2x_2d: RTL and testbench
=========================================

# upsample_nearest_2x_2d

Streaming 2x nearest-neighbour upsampler for single-channel feature maps, the inverse of the 2D pooling stage. It sits after a pooling or convolution stage's output FIFO in decoder paths. It accepts an IMG_Width x IMG_Height raster stream and emits a (2·IMG_Width) x (2·IMG_Height) raster stream: each pixel is repeated twice horizontally, and each row is repeated twice vertically from an internal row buffer. A ready signal throttles the upstream FIFO, because the block produces four outputs per input.

## Interface
- IMG_Width, 3, input row length in pixels (≥2)
- IMG_Height, 3, input rows per frame (≥1)
- Datawidth, 16, pixel width; two's-complement data passes through unmodified

- CLK  input  1  clock; all state changes on the rising edge
- CLR  input  1  asynchronous, active-high reset
- In  input  Datawidth  input pixel, raster order
- Valid_IN  input  1  In is valid this cycle
- Ready  output  1  combinational; block accepts In this cycle
- Out  output  Datawidth  registered output pixel
- Valid_OUT  output  1  registered; Out is valid this cycle
- Frame_Done  output  1  registered; one-cycle pulse coincident with the last output pixel of a frame

## Operation
- Accept condition: Valid_IN && Ready at a rising edge.
  - Valid_IN while Ready=0 is ignored; no data is stored or emitted.
  - Upstream must hold In until it is accepted.
- Internal state:
  - row buffer buf[0..IMG_Width-1], Datawidth bits each, not reset
  - column counter cot and row counter hang, each $clog2-sized, minimum 1 bit
  - phase bit ph
- FSM states:
  - FILL_A: Ready=1. On accept: buf[cot]<=In; Out<=In; Valid_OUT<=1; go to FILL_B. With no accept: Valid_OUT<=0 and stay.
  - FILL_B: Ready=0. Out holds its value; Valid_OUT<=1.
    - If cot==IMG_Width-1: cot<=0, ph<=0, go to REPLAY.
    - Otherwise: cot<=cot+1, go to FILL_A.
  - REPLAY: Ready=0. Each cycle: Out<=buf[cot]; Valid_OUT<=1; ph<=~ph.
    - When ph==1, cot advances.
    - When ph==1 and cot==IMG_Width-1: cot<=0 and go to FILL_A.
      - If hang==IMG_Height-1: hang<=0 and Frame_Done<=1 (same edge).
      - Otherwise: hang<=hang+1.
- Output order per input row r: p0 p0 p1 p1 … p(W-1) p(W-1), then the same 2W values again.
- Frame totals: 4·IMG_Width·IMG_Height outputs per frame. The next frame begins with no idle cycle and no flush required.
- No arithmetic is performed. Out is bit-identical to the stored pixel, including sign.

## Timing
- Reset (CLR=1, asynchronous):
  - Out=0, Valid_OUT=0, Frame_Done=0
  - state=FILL_A, cot=0, hang=0, ph=0
  - Ready=1 as soon as CLR deasserts
- Latency: a pixel accepted at edge k appears on Out after edge k and again after edge k+1.
- Row replay starts at the edge after the second copy of the last pixel, with zero bubble cycles.
- Minimum cycles per input row is 4·IMG_Width: W accepts, W FILL_B cycles and 2W REPLAY cycles. The output stream is gap-free whenever Valid_IN is high in every FILL_A cycle.
- Ready is low in FILL_B and REPLAY regardless of Valid_IN.
- Gaps on Valid_IN during FILL_A produce matching gaps on Valid_OUT. REPLAY is never interrupted.
- CLR asserted mid-row or mid-REPLAY aborts immediately. Partially buffered data is discarded, and the next accepted pixel is treated as row 0, column 0.
- Frame_Done is asserted only together with Valid_OUT=1.

## Test plan
- W=3, H=3. Feed 1..9, Valid_IN driven high whenever Ready=1.
  - Expect 36 outputs with no gaps, starting 1,1,2,2,3,3,1,1,2,2,3,3,4,4,5,5,6,6,4,4,… and ending …9,9.
  - Frame_Done pulses only with the 36th output.
- Valid_IN held high with In changing every cycle, regardless of Ready.
  - Only values present in FILL_A cycles are captured.
  - Output count is exactly 4 per accepted pixel.
- Insert 2-cycle Valid_IN gaps before pixels 2 and 5.
  - Valid_OUT shows matching gaps only in FILL phases.
  - Data order is unchanged versus scenario 1.
- Feed 16'hFFF0, 16'h8000, 16'h7FFF, … (negative and extreme values).
  - Outputs are bit-identical with no sign alteration.
- Assert CLR between clock edges during the second REPLAY output of row 1.
  - Out=0, Valid_OUT=0 and Ready=1 immediately, before the next edge.
  - A fresh frame 1..9 then reproduces the scenario 1 sequence exactly.
- Two back-to-back frames (1..9, then 11..19).
  - 72 contiguous outputs, with Frame_Done at outputs 36 and 72.
  - The second frame starts with 11,11,12,12.

Source files
------------

// File: rtl/upsample_nearest_2x_2d_if.sv
`default_nettype none
// ============================================================================
// Module   : upsample_nearest_2x_2d_if
// Purpose  : Stream bundle for the 2x nearest-neighbour upsampler.
//            The upstream side delivers pixels with a valid/ready handshake.
//            The downstream side is a valid-only output stream with an
//            end-of-frame pulse.
// Ports    : In / Valid_IN / Ready       - input pixel stream and throttle
//            Out / Valid_OUT / Frame_Done - output pixel stream
// Modports : master - environment side (drives In/Valid_IN)
//            slave  - upsampler side  (drives Ready/Out/Valid_OUT/Frame_Done)
// Revision : 1.0 - initial release
// ============================================================================
interface upsample_nearest_2x_2d_if #(
  parameter int Datawidth = 16
);
  logic [Datawidth-1:0] In;
  logic                 Valid_IN;
  logic                 Ready;
  logic [Datawidth-1:0] Out;
  logic                 Valid_OUT;
  logic                 Frame_Done;

  modport master (
    output In, Valid_IN,
    input  Ready, Out, Valid_OUT, Frame_Done
  );

  modport slave (
    input  In, Valid_IN,
    output Ready, Out, Valid_OUT, Frame_Done
  );
endinterface
`default_nettype wire

// File: rtl/upsample_nearest_2x_2d.sv
`default_nettype none
// ============================================================================
// Module   : upsample_nearest_2x_2d
// Purpose  : Streaming 2x nearest-neighbour upsampler. Each pixel of an
//            IMG_Width x IMG_Height raster is emitted twice horizontally, and
//            every row is replayed once from an internal row buffer, giving a
//            (2*IMG_Width) x (2*IMG_Height) raster. Pixels pass through
//            bit-identical.
// Ports    : CLK - clock, rising edge
//            CLR - asynchronous active-high reset
//            bus - upsample_nearest_2x_2d_if.slave
//                  In/Valid_IN in, Ready out (combinational),
//                  Out/Valid_OUT/Frame_Done out (registered)
// Revision : 1.0 - initial release
// ============================================================================
module upsample_nearest_2x_2d #(
  parameter int IMG_Width  = 3,
  parameter int IMG_Height = 3,
  parameter int Datawidth  = 16
) (
  input wire logic           CLK,
  input wire logic           CLR,
  upsample_nearest_2x_2d_if.slave bus
);

  localparam int CW = (IMG_Width  > 1) ? $clog2(IMG_Width)  : 1;
  localparam int HW = (IMG_Height > 1) ? $clog2(IMG_Height) : 1;

  localparam logic [CW-1:0] c_last_col = CW'(IMG_Width - 1);
  localparam logic [HW-1:0] c_last_row = HW'(IMG_Height - 1);

  typedef enum logic [1:0] {
    FILL_A = 2'd0,  // waiting to accept the next pixel of the row
    FILL_B = 2'd1,  // emitting the second copy of the pixel just accepted
    REPLAY = 2'd2   // re-emitting the whole buffered row, two copies each
  } state_t;

  state_t               r_state;
  state_t               w_state_n;
  logic [CW-1:0]        r_cot;
  logic [CW-1:0]        w_cot_n;
  logic [HW-1:0]        r_hang;
  logic [HW-1:0]        w_hang_n;
  logic                 r_ph;
  logic                 w_ph_n;
  logic [Datawidth-1:0] r_out;
  logic [Datawidth-1:0] w_out_n;
  logic                 r_valid_out;
  logic                 w_valid_out_n;
  logic                 r_frame_done;
  logic                 w_frame_done_n;
  logic                 w_accept;

  // Row buffer is deliberately left without reset: every entry is rewritten
  // during FILL before REPLAY ever reads it.
  logic [Datawidth-1:0] r_buf [IMG_Width];

  assign bus.Ready      = (r_state == FILL_A);
  assign w_accept       = bus.Valid_IN && (r_state == FILL_A);
  assign bus.Out        = r_out;
  assign bus.Valid_OUT  = r_valid_out;
  assign bus.Frame_Done = r_frame_done;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state      <= FILL_A;
      r_cot        <= '0;
      r_hang       <= '0;
      r_ph         <= 1'b0;
      r_out        <= '0;
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_cot        <= w_cot_n;
      r_hang       <= w_hang_n;
      r_ph         <= w_ph_n;
      r_out        <= w_out_n;
      r_valid_out  <= w_valid_out_n;
      r_frame_done <= w_frame_done_n;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_buf[r_cot] <= bus.In;
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_cot_n        = r_cot;
    w_hang_n       = r_hang;
    w_ph_n         = r_ph;
    w_out_n        = r_out;
    w_valid_out_n  = 1'b0;
    w_frame_done_n = 1'b0;

    unique case (r_state)
      FILL_A: begin
        if (bus.Valid_IN) begin
          w_out_n       = bus.In;
          w_valid_out_n = 1'b1;
          w_state_n     = FILL_B;
        end
      end

      FILL_B: begin
        // Out keeps the pixel just accepted: this is its second copy.
        w_valid_out_n = 1'b1;
        if (r_cot == c_last_col) begin
          w_cot_n   = '0;
          w_ph_n    = 1'b0;
          w_state_n = REPLAY;
        end else begin
          w_cot_n   = r_cot + CW'(1);
          w_state_n = FILL_A;
        end
      end

      REPLAY: begin
        // ph selects first/second copy; the column advances after the second.
        w_out_n       = r_buf[r_cot];
        w_valid_out_n = 1'b1;
        w_ph_n        = ~r_ph;
        if (r_ph) begin
          if (r_cot == c_last_col) begin
            w_cot_n   = '0;
            w_state_n = FILL_A;
            if (r_hang == c_last_row) begin
              w_hang_n       = '0;
              w_frame_done_n = 1'b1;
            end else begin
              w_hang_n = r_hang + HW'(1);
            end
          end else begin
            w_cot_n = r_cot + CW'(1);
          end
        end
      end

      default: begin
        w_state_n = FILL_A;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_upsample_nearest_2x_2d.sv
`default_nettype none
// ============================================================================
// Module   : tb_upsample_nearest_2x_2d
// Purpose  : Self-checking bench for upsample_nearest_2x_2d (W=3, H=3).
//            Table of input frames applied in a loop against a reference
//            ordering model, plus hand sequences for free-running Valid_IN
//            and reset in the middle of a row replay.
// Revision : 1.0 - initial release
// ============================================================================
module tb_upsample_nearest_2x_2d;

  localparam int W  = 3;
  localparam int H  = 3;
  localparam int DW = 16;

  logic CLK = 1'b0;
  logic CLR = 1'b1;

  upsample_nearest_2x_2d_if #(.Datawidth(DW)) bus ();

  upsample_nearest_2x_2d #(
    .IMG_Width (W),
    .IMG_Height(H),
    .Datawidth (DW)
  ) dut (
    .CLK(CLK),
    .CLR(CLR),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          scen;
    logic [15:0] px;
    int          gap;   // idle Valid_IN cycles in FILL_A before this pixel
  } stim_t;

  typedef struct {
    logic [15:0] data;
    logic        fd;
    int          cyc;
  } obs_t;

  typedef struct {
    logic [15:0] data;
    logic        fd;
  } exp_t;

  stim_t       tbl[$];
  obs_t        got[$];
  exp_t        exp_q[$];
  logic [15:0] px_q[$];

  int cyc       = 0;
  int orphan_fd = 0;
  int n_checks  = 0;
  int n_fail    = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (bus.Valid_OUT) got.push_back('{bus.Out, bus.Frame_Done, cyc});
    if (bus.Frame_Done && !bus.Valid_OUT) orphan_fd++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  // Output order: per input row, p0 p0 p1 p1 .. twice; Frame_Done on the
  // last output of every W*H-pixel frame.
  task automatic build_exp();
    exp_q.delete();
    for (int b = 0; b + W*H <= px_q.size(); b += W*H)
      for (int r = 0; r < H; r++)
        for (int rep = 0; rep < 2; rep++)
          for (int c = 0; c < W; c++)
            for (int k = 0; k < 2; k++)
              exp_q.push_back('{px_q[b + r*W + c],
                                (r == H-1) && (rep == 1) && (c == W-1) && (k == 1)});
  endtask

  task automatic send(input logic [15:0] p, input int gap);
    int i;
    bus.In       = p;
    bus.Valid_IN = (gap == 0);
    for (i = 0; i < 100 && !bus.Ready; i++) @(negedge CLK);
    if (!bus.Ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready timeout: got 0, expected 1");
    end
    repeat (gap) @(negedge CLK);
    bus.Valid_IN = 1'b1;
    @(negedge CLK);
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 400 && got.size() < n; i++) @(posedge CLK);
    repeat (4) @(posedge CLK);
  endtask

  task automatic check_stream(input string nm, input int extra_span);
    int n;
    chk({nm, " count"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s data[%0d]", nm, i), got[i].data, exp_q[i].data);
      chk($sformatf("%s fd[%0d]", nm, i), got[i].fd, exp_q[i].fd);
    end
    if (n > 0)
      chk({nm, " span"}, got[n-1].cyc - got[0].cyc, n - 1 + extra_span);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    CLR = 1'b1;
    repeat (2) @(negedge CLK);
    CLR = 1'b0;
    got.delete();
  endtask

  initial begin
    int scens[4];
    int gaps;

    bus.In       = '0;
    bus.Valid_IN = 1'b0;

    // ---- stimulus table -------------------------------------------------
    for (int i = 0; i < 9; i++) tbl.push_back('{1, 16'(i + 1), 0});
    for (int i = 0; i < 9; i++) tbl.push_back('{3, 16'(i + 1), (i == 1 || i == 4) ? 2 : 0});
    tbl.push_back('{4, 16'hFFF0, 0});
    tbl.push_back('{4, 16'h8000, 0});
    tbl.push_back('{4, 16'h7FFF, 0});
    tbl.push_back('{4, 16'h0001, 0});
    tbl.push_back('{4, 16'hFFFF, 0});
    tbl.push_back('{4, 16'h0000, 0});
    tbl.push_back('{4, 16'h8001, 0});
    tbl.push_back('{4, 16'h7FFE, 0});
    tbl.push_back('{4, 16'h00FF, 0});
    for (int i = 0; i < 9; i++) tbl.push_back('{6, 16'(i + 1), 0});
    for (int i = 0; i < 9; i++) tbl.push_back('{6, 16'(i + 11), 0});
    scens = '{1, 3, 4, 6};

    // ---- reset state ----------------------------------------------------
    @(negedge CLK);
    chk("reset Out", bus.Out, 0);
    chk("reset Valid_OUT", bus.Valid_OUT, 0);
    chk("reset Frame_Done", bus.Frame_Done, 0);
    CLR = 1'b0;
    #1;
    chk("reset Ready", bus.Ready, 1);

    // ---- table-driven frames --------------------------------------------
    foreach (scens[s]) begin
      do_reset();
      px_q.delete();
      gaps = 0;
      for (int i = 0; i < tbl.size(); i++) begin
        if (tbl[i].scen == scens[s]) begin
          send(tbl[i].px, tbl[i].gap);
          px_q.push_back(tbl[i].px);
          gaps += tbl[i].gap;
        end
      end
      bus.Valid_IN = 1'b0;
      build_exp();
      wait_out(exp_q.size());
      check_stream($sformatf("scen%0d", scens[s]), gaps);
    end

    // ---- Valid_IN always high, In changing every cycle --------------------
    // Row timing A B A B A B R R R R R R: captures at t = 0,2,4 of each row.
    do_reset();
    for (int t = 0; t < 36; t++) begin
      bus.In       = 16'(100 + t);
      bus.Valid_IN = 1'b1;
      if (t == 1) chk("free Ready in FILL_B", bus.Ready, 0);
      if (t == 6) chk("free Ready in REPLAY", bus.Ready, 0);
      @(negedge CLK);
    end
    bus.Valid_IN = 1'b0;
    px_q = '{16'd100, 16'd102, 16'd104, 16'd112, 16'd114, 16'd116,
             16'd124, 16'd126, 16'd128};
    build_exp();
    wait_out(36);
    check_stream("free", 0);

    // ---- reset during the second REPLAY output of row 1 ------------------
    do_reset();
    for (int i = 0; i < 6; i++) send(16'(i + 1), 0);
    bus.Valid_IN = 1'b0;
    repeat (3) @(negedge CLK);
    #2;
    chk("midrst count before", got.size(), 20);
    if (got.size() == 20) chk("midrst last before", got[19].data, 4);
    CLR = 1'b1;
    #1;
    chk("midrst Out", bus.Out, 0);
    chk("midrst Valid_OUT", bus.Valid_OUT, 0);
    chk("midrst Ready", bus.Ready, 1);
    chk("midrst Frame_Done", bus.Frame_Done, 0);
    @(negedge CLK);
    CLR = 1'b0;
    got.delete();
    px_q.delete();
    for (int i = 0; i < 9; i++) begin
      send(16'(i + 1), 0);
      px_q.push_back(16'(i + 1));
    end
    bus.Valid_IN = 1'b0;
    build_exp();
    wait_out(36);
    check_stream("after_rst", 0);

    chk("Frame_Done without Valid_OUT", orphan_fd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
